// File: rtl/control_multi_pkg.sv
// rtl/control_multi_pkg.sv - shared encodings for the multicycle RV32I control unit
// Contents: FSM state codes, opcode/funct3/funct7 constants, ALU operation
// codes, datapath mux-select encodings, the control-strobe bundle type and a
// funct3 legality helper for load/store/branch.
package control_multi_pkg;

  typedef enum logic [5:0] {
    S_FETCH     = 6'd0,
    S_DECODE    = 6'd1,
    S_EXE_R     = 6'd2,
    S_EXE_I     = 6'd3,
    S_EXE_LUI   = 6'd4,
    S_EXE_AUIPC = 6'd5,
    S_ALU_WB    = 6'd6,
    S_ADDR      = 6'd7,
    S_LOAD_MEM  = 6'd8,
    S_LOAD_WB   = 6'd9,
    S_STORE_MEM = 6'd10,
    S_BRANCH    = 6'd11,
    S_JAL       = 6'd12,
    S_JALR      = 6'd13,
    S_CSR_EXE   = 6'd14,
    S_CSR_WB    = 6'd15,
    S_ECALL     = 6'd16,
    S_URET      = 6'd17,
    S_INVALID   = 6'd18
  } state_e;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;

  localparam logic [2:0] F3_PRIV    = 3'b000;
  localparam logic [2:0] F3_CSRRW   = 3'b001;
  localparam logic [2:0] F3_CSRRS   = 3'b010;
  localparam logic [2:0] F3_CSRRC   = 3'b011;
  localparam logic [2:0] F3_SYSRSVD = 3'b100;
  localparam logic [2:0] F3_CSRRWI  = 3'b101;
  localparam logic [2:0] F3_CSRRSI  = 3'b110;
  localparam logic [2:0] F3_CSRRCI  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [11:0] IMM_ECALL = 12'h000;
  localparam logic [11:0] IMM_URET  = 12'h002;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;
  localparam logic [4:0] ALU_CLR  = 5'd10;  // ~A & B

  localparam logic [2:0] A_REG    = 3'b000;
  localparam logic [2:0] A_PC     = 3'b001;
  localparam logic [2:0] A_PCBACK = 3'b010;
  localparam logic [2:0] A_IMM    = 3'b011;
  localparam logic [2:0] A_NOT    = 3'b100;
  localparam logic [2:0] A_ZERO   = 3'b101;

  localparam logic [2:0] B_REG  = 3'b000;
  localparam logic [2:0] B_FOUR = 3'b001;
  localparam logic [2:0] B_IMM  = 3'b010;
  localparam logic [2:0] B_CSR  = 3'b011;
  localparam logic [2:0] B_ZERO = 3'b100;

  localparam logic [2:0] M2R_ALUOUT = 3'b000;
  localparam logic [2:0] M2R_PC     = 3'b001;
  localparam logic [2:0] M2R_MDR    = 3'b010;
  localparam logic [2:0] M2R_CSR    = 3'b100;

  localparam logic [2:0] PC_ALU    = 3'b000;
  localparam logic [2:0] PC_ALUOUT = 3'b001;
  localparam logic [2:0] PC_JALR   = 3'b010;
  localparam logic [2:0] PC_UTVEC  = 3'b011;
  localparam logic [2:0] PC_UEPC   = 3'b100;

  typedef struct packed {
    logic       escreve_ir;
    logic       escreve_pc;
    logic       escreve_pc_cond;
    logic       escreve_pc_back;
    logic [2:0] orig_a;
    logic [2:0] orig_b;
    logic [2:0] mem2reg;
    logic [2:0] orig_pc;
    logic       iord;
    logic       reg_write;
    logic       csr_write;
    logic       mem_write;
    logic       mem_read;
    logic [4:0] alu_op;
    logic       ecall;
    logic       inv;
  } ctrl_t;

  // Rejects the funct3 holes RV32I leaves in load, store and branch.
  function automatic logic funct3_legal(input logic [6:0] opcode, input logic [2:0] funct3);
    logic ok;
    ok = 1'b1;
    case (opcode)
      OPC_LOAD:   ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      OPC_STORE:  ok = (funct3 <= 3'b010);
      OPC_BRANCH: ok = (funct3 != 3'b010) && (funct3 != 3'b011);
      default:    ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/control_multi_if.sv
// rtl/control_multi_if.sv - control bundle between control unit and datapath
// iInstr: IR contents into the control unit.
// oState and o* strobes/selects: control unit outputs to datapath and exception logic.
interface control_multi_if;
  logic [31:0] iInstr;
  logic [5:0]  oState;
  logic        oEscreveIR;
  logic        oEscrevePC;
  logic        oEscrevePCCond;
  logic        oEscrevePCBack;
  logic [2:0]  oOrigAULA;
  logic [2:0]  oOrigBULA;
  logic [2:0]  oMem2Reg;
  logic [2:0]  oOrigPC;
  logic        oIouD;
  logic        oRegWrite;
  logic        oCSRegWrite;
  logic        oMemWrite;
  logic        oMemRead;
  logic [4:0]  oALUControl;
  logic        oEcall;
  logic        oInvInstruction;

  modport master (
    input  iInstr,
    output oState, oEscreveIR, oEscrevePC, oEscrevePCCond, oEscrevePCBack,
    output oOrigAULA, oOrigBULA, oMem2Reg, oOrigPC, oIouD,
    output oRegWrite, oCSRegWrite, oMemWrite, oMemRead, oALUControl,
    output oEcall, oInvInstruction
  );

  modport slave (
    output iInstr,
    input  oState, oEscreveIR, oEscrevePC, oEscrevePCCond, oEscrevePCBack,
    input  oOrigAULA, oOrigBULA, oMem2Reg, oOrigPC, oIouD,
    input  oRegWrite, oCSRegWrite, oMemWrite, oMemRead, oALUControl,
    input  oEcall, oInvInstruction
  );
endinterface

// File: rtl/control_multi_alu_op_decode.sv
// rtl/control_multi_alu_op_decode.sv - ALU operation and legality decode for OP / OP-IMM
// opcode_i, funct3_i, funct7_i: instruction fields.
// alu_op_o: ALU operation code; valid_o: 1 when the encoding is a legal RV32I OP/OP-IMM.
module control_multi_alu_op_decode
  import control_multi_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [4:0] alu_op_o,
  output logic       valid_o
);

  logic is_r;
  logic is_i;

  assign is_r = (opcode_i == OPC_RTYPE);
  assign is_i = (opcode_i == OPC_ITYPE);

  always_comb begin
    alu_op_o = ALU_ADD;
    valid_o  = 1'b0;
    if (is_r || is_i) begin
      case (funct3_i)
        F3_ADD_SUB: alu_op_o = (is_r && funct7_i[5]) ? ALU_SUB : ALU_ADD;
        F3_SLL:     alu_op_o = ALU_SLL;
        F3_SLT:     alu_op_o = ALU_SLT;
        F3_SLTU:    alu_op_o = ALU_SLTU;
        F3_XOR:     alu_op_o = ALU_XOR;
        F3_SR:      alu_op_o = funct7_i[5] ? ALU_SRA : ALU_SRL;
        F3_OR:      alu_op_o = ALU_OR;
        default:    alu_op_o = ALU_AND;
      endcase
      // OP-IMM carries immediate bits in funct7 except for the shifts.
      if (is_r) begin
        valid_o = (funct7_i == F7_BASE) ||
                  ((funct7_i == F7_ALT) && ((funct3_i == F3_ADD_SUB) || (funct3_i == F3_SR)));
      end else if (funct3_i == F3_SLL) begin
        valid_o = (funct7_i == F7_BASE);
      end else if (funct3_i == F3_SR) begin
        valid_o = (funct7_i == F7_BASE) || (funct7_i == F7_ALT);
      end else begin
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/control_multi.sv
// rtl/control_multi.sv - multicycle RV32I control FSM driving datapath strobes and selects
// iCLK: core clock. iRST: synchronous active-low reset.
// bus (master): iInstr in; oState, write enables, mux selects, ALU code and
// ecall/illegal flags out, all decoded from the current state and iInstr.
module control_multi (
  input  logic            iCLK,
  input  logic            iRST,
  control_multi_if.master bus
);
  import control_multi_pkg::*;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rd;
  logic [11:0] imm12;

  assign opcode = bus.iInstr[6:0];
  assign rd     = bus.iInstr[11:7];
  assign funct3 = bus.iInstr[14:12];
  assign rs1    = bus.iInstr[19:15];
  assign funct7 = bus.iInstr[31:25];
  assign imm12  = bus.iInstr[31:20];

  state_e     state_q;
  state_e     state_d;
  ctrl_t      ctrl;
  ctrl_t      ctrl_gated;
  logic [4:0] dec_alu_op;
  logic       dec_valid;
  logic       sys_plain;

  // ecall/uret are only those encodings with rd and rs1 both x0.
  assign sys_plain = (rd == 5'd0) && (rs1 == 5'd0);

  control_multi_alu_op_decode u_alu_op_decode (
    .opcode_i (opcode),
    .funct3_i (funct3),
    .funct7_i (funct7),
    .alu_op_o (dec_alu_op),
    .valid_o  (dec_valid)
  );

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OPC_RTYPE:  state_d = dec_valid ? S_EXE_R : S_INVALID;
          OPC_ITYPE:  state_d = dec_valid ? S_EXE_I : S_INVALID;
          OPC_LUI:    state_d = S_EXE_LUI;
          OPC_AUIPC:  state_d = S_EXE_AUIPC;
          OPC_LOAD,
          OPC_STORE:  state_d = funct3_legal(opcode, funct3) ? S_ADDR : S_INVALID;
          OPC_BRANCH: state_d = funct3_legal(opcode, funct3) ? S_BRANCH : S_INVALID;
          OPC_JAL:    state_d = S_JAL;
          OPC_JALR:   state_d = S_JALR;
          OPC_FENCE:  state_d = S_FETCH;
          OPC_SYSTEM: begin
            if (funct3 == F3_PRIV) begin
              if (sys_plain && (imm12 == IMM_ECALL))     state_d = S_ECALL;
              else if (sys_plain && (imm12 == IMM_URET)) state_d = S_URET;
              else                                       state_d = S_INVALID;
            end else if (funct3 == F3_SYSRSVD) begin
              state_d = S_INVALID;
            end else begin
              state_d = S_CSR_EXE;
            end
          end
          default:    state_d = S_INVALID;
        endcase
      end
      S_EXE_R, S_EXE_I, S_EXE_LUI, S_EXE_AUIPC: state_d = S_ALU_WB;
      S_ADDR:     state_d = (opcode == OPC_STORE) ? S_STORE_MEM : S_LOAD_MEM;
      S_LOAD_MEM: state_d = S_LOAD_WB;
      S_CSR_EXE:  state_d = S_CSR_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ctrl.iord            = 1'b0;
        ctrl.mem_read        = 1'b1;
        ctrl.escreve_ir      = 1'b1;
        ctrl.escreve_pc_back = 1'b1;
        ctrl.orig_a          = A_PC;
        ctrl.orig_b          = B_FOUR;
        ctrl.orig_pc         = PC_ALU;
        ctrl.escreve_pc      = 1'b1;
      end
      // ALUOut captures PCBack+Imm here so BRANCH/JAL find their target ready.
      S_DECODE: begin
        ctrl.orig_a = A_PCBACK;
        ctrl.orig_b = B_IMM;
      end
      S_EXE_R: begin
        ctrl.orig_a = A_REG;
        ctrl.orig_b = B_REG;
        ctrl.alu_op = dec_alu_op;
      end
      S_EXE_I: begin
        ctrl.orig_a = A_REG;
        ctrl.orig_b = B_IMM;
        ctrl.alu_op = dec_alu_op;
      end
      S_EXE_LUI: begin
        ctrl.orig_a = A_ZERO;
        ctrl.orig_b = B_IMM;
      end
      S_EXE_AUIPC: begin
        ctrl.orig_a = A_PCBACK;
        ctrl.orig_b = B_IMM;
      end
      S_ALU_WB: begin
        ctrl.mem2reg   = M2R_ALUOUT;
        ctrl.reg_write = 1'b1;
      end
      S_ADDR: begin
        ctrl.orig_a = A_REG;
        ctrl.orig_b = B_IMM;
      end
      S_LOAD_MEM: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_LOAD_WB: begin
        ctrl.mem2reg   = M2R_MDR;
        ctrl.reg_write = 1'b1;
      end
      S_STORE_MEM: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.escreve_pc_cond = 1'b1;
        ctrl.orig_pc         = PC_ALUOUT;
      end
      // PC already holds PCBack+4 from FETCH, so it is the link value.
      S_JAL: begin
        ctrl.mem2reg    = M2R_PC;
        ctrl.reg_write  = 1'b1;
        ctrl.orig_pc    = PC_ALUOUT;
        ctrl.escreve_pc = 1'b1;
      end
      S_JALR: begin
        ctrl.orig_a     = A_REG;
        ctrl.orig_b     = B_IMM;
        ctrl.orig_pc    = PC_JALR;
        ctrl.escreve_pc = 1'b1;
        ctrl.mem2reg    = M2R_PC;
        ctrl.reg_write  = 1'b1;
      end
      S_CSR_EXE: begin
        case (funct3)
          F3_CSRRW: begin
            ctrl.orig_a = A_REG;
            ctrl.orig_b = B_ZERO;
          end
          F3_CSRRS: begin
            ctrl.orig_a = A_REG;
            ctrl.orig_b = B_CSR;
            ctrl.alu_op = ALU_OR;
          end
          F3_CSRRC: begin
            ctrl.orig_a = A_NOT;
            ctrl.orig_b = B_CSR;
            ctrl.alu_op = ALU_AND;
          end
          F3_CSRRWI: begin
            ctrl.orig_a = A_IMM;
            ctrl.orig_b = B_ZERO;
          end
          F3_CSRRSI: begin
            ctrl.orig_a = A_IMM;
            ctrl.orig_b = B_CSR;
            ctrl.alu_op = ALU_OR;
          end
          // No A select inverts the immediate, so the ALU does the complement.
          F3_CSRRCI: begin
            ctrl.orig_a = A_IMM;
            ctrl.orig_b = B_CSR;
            ctrl.alu_op = ALU_CLR;
          end
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      S_CSR_WB: begin
        ctrl.mem2reg   = M2R_CSR;
        ctrl.reg_write = 1'b1;
        // Set/clear forms (funct3[1]=1) with rs1/zimm = 0 must not touch the CSR.
        ctrl.csr_write = !(funct3[1] && (rs1 == 5'd0));
      end
      S_ECALL: begin
        ctrl.ecall      = 1'b1;
        ctrl.orig_pc    = PC_UTVEC;
        ctrl.escreve_pc = 1'b1;
      end
      S_URET: begin
        ctrl.orig_pc    = PC_UEPC;
        ctrl.escreve_pc = 1'b1;
      end
      S_INVALID: ctrl.inv = 1'b1;
      default:   ctrl.alu_op = ALU_ADD;
    endcase
  end

  // Reset is visible on the outputs immediately, not only after the next edge.
  assign ctrl_gated = iRST ? ctrl : '0;
  assign bus.oState = iRST ? state_q : S_FETCH;

  assign bus.oEscreveIR      = ctrl_gated.escreve_ir;
  assign bus.oEscrevePC      = ctrl_gated.escreve_pc;
  assign bus.oEscrevePCCond  = ctrl_gated.escreve_pc_cond;
  assign bus.oEscrevePCBack  = ctrl_gated.escreve_pc_back;
  assign bus.oOrigAULA       = ctrl_gated.orig_a;
  assign bus.oOrigBULA       = ctrl_gated.orig_b;
  assign bus.oMem2Reg        = ctrl_gated.mem2reg;
  assign bus.oOrigPC         = ctrl_gated.orig_pc;
  assign bus.oIouD           = ctrl_gated.iord;
  assign bus.oRegWrite       = ctrl_gated.reg_write;
  assign bus.oCSRegWrite     = ctrl_gated.csr_write;
  assign bus.oMemWrite       = ctrl_gated.mem_write;
  assign bus.oMemRead        = ctrl_gated.mem_read;
  assign bus.oALUControl     = ctrl_gated.alu_op;
  assign bus.oEcall          = ctrl_gated.ecall;
  assign bus.oInvInstruction = ctrl_gated.inv;

endmodule

// File: tb/tb_control_multi.sv
// tb/tb_control_multi.sv - directed scoreboard bench for control_multi
module tb_control_multi;
  import control_multi_pkg::*;

  logic iCLK = 1'b0;
  logic iRST = 1'b0;

  control_multi_if bus ();

  control_multi dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [5:0] st;
    logic       ir, pc, pcc, pcb;
    logic [2:0] a, b, m2r, opc;
    logic       iord, rw, csrw, mw, mr;
    logic [4:0] alu;
    logic       ecall, inv;
  } ctl_t;

  typedef struct {
    string tag;
    ctl_t  v;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic ctl_t observe();
    ctl_t o;
    o.st    = bus.oState;
    o.ir    = bus.oEscreveIR;
    o.pc    = bus.oEscrevePC;
    o.pcc   = bus.oEscrevePCCond;
    o.pcb   = bus.oEscrevePCBack;
    o.a     = bus.oOrigAULA;
    o.b     = bus.oOrigBULA;
    o.m2r   = bus.oMem2Reg;
    o.opc   = bus.oOrigPC;
    o.iord  = bus.oIouD;
    o.rw    = bus.oRegWrite;
    o.csrw  = bus.oCSRegWrite;
    o.mw    = bus.oMemWrite;
    o.mr    = bus.oMemRead;
    o.alu   = bus.oALUControl;
    o.ecall = bus.oEcall;
    o.inv   = bus.oInvInstruction;
    return o;
  endfunction

  function automatic ctl_t base(input logic [5:0] st);
    ctl_t c;
    c     = '0;
    c.st  = st;
    c.alu = ALU_ADD;
    return c;
  endfunction

  function automatic ctl_t ex(input logic [5:0] st, input logic [2:0] a, input logic [2:0] b,
                              input logic [4:0] alu);
    ctl_t c;
    c     = base(st);
    c.a   = a;
    c.b   = b;
    c.alu = alu;
    return c;
  endfunction

  task automatic push(input string tag, input ctl_t v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic push_fd(input string name);
    ctl_t c;
    c     = base(6'd0);
    c.mr  = 1'b1;
    c.ir  = 1'b1;
    c.pcb = 1'b1;
    c.a   = A_PC;
    c.b   = B_FOUR;
    c.opc = PC_ALU;
    c.pc  = 1'b1;
    push({name, "_fetch"}, c);
    push({name, "_decode"}, ex(6'd1, A_PCBACK, B_IMM, ALU_ADD));
  endtask

  task automatic push_alu_wb(input string name);
    ctl_t c;
    c     = base(S_ALU_WB);
    c.m2r = M2R_ALUOUT;
    c.rw  = 1'b1;
    push({name, "_wb"}, c);
  endtask

  task automatic push_csr_wb(input string name, input logic csrw);
    ctl_t c;
    c      = base(S_CSR_WB);
    c.m2r  = M2R_CSR;
    c.rw   = 1'b1;
    c.csrw = csrw;
    push({name, "_csrwb"}, c);
  endtask

  task automatic push_invalid(input string name);
    ctl_t c;
    push_fd(name);
    c     = base(S_INVALID);
    c.inv = 1'b1;
    push({name, "_inv"}, c);
  endtask

  // One scoreboard entry per clock; instruction and reset level change just after a falling edge.
  task automatic drain(input logic [31:0] instr, input logic rst);
    exp_t e;
    ctl_t o;
    bit   first;
    first = 1'b1;
    while (sb.size() > 0) begin
      @(negedge iCLK);
      if (first) begin
        iRST       = rst;
        bus.iInstr = instr;
        first      = 1'b0;
      end
      #1;
      e = sb.pop_front();
      o = observe();
      checks++;
      assert (o === e.v) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.v);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    ctl_t c;
    bus.iInstr = 32'h0080A203;
    iRST       = 1'b0;

    push("reset0", '0);
    push("reset1", '0);
    drain(32'h0080A203, 1'b0);

    push_fd("add");
    push("add_exe", ex(S_EXE_R, A_REG, B_REG, ALU_ADD));
    push_alu_wb("add");
    drain(32'h002081B3, 1'b1);

    push_fd("sub");
    push("sub_exe", ex(S_EXE_R, A_REG, B_REG, ALU_SUB));
    push_alu_wb("sub");
    drain(32'h402081B3, 1'b1);

    push_fd("srai");
    push("srai_exe", ex(S_EXE_I, A_REG, B_IMM, ALU_SRA));
    push_alu_wb("srai");
    drain(32'h4030D293, 1'b1);

    push_fd("lui");
    push("lui_exe", ex(S_EXE_LUI, A_ZERO, B_IMM, ALU_ADD));
    push_alu_wb("lui");
    drain(32'h100100B7, 1'b1);

    push_fd("lw");
    push("lw_addr", ex(S_ADDR, A_REG, B_IMM, ALU_ADD));
    c      = base(S_LOAD_MEM);
    c.iord = 1'b1;
    c.mr   = 1'b1;
    push("lw_mem", c);
    c      = base(S_LOAD_WB);
    c.m2r  = M2R_MDR;
    c.rw   = 1'b1;
    push("lw_wb", c);
    drain(32'h0080A203, 1'b1);

    push_fd("sw");
    push("sw_addr", ex(S_ADDR, A_REG, B_IMM, ALU_ADD));
    c      = base(S_STORE_MEM);
    c.iord = 1'b1;
    c.mw   = 1'b1;
    push("sw_mem", c);
    drain(32'h0020A223, 1'b1);

    push_fd("beq");
    c      = base(S_BRANCH);
    c.pcc  = 1'b1;
    c.opc  = PC_ALUOUT;
    push("beq_br", c);
    drain(32'hFE000CE3, 1'b1);

    push_fd("bne");
    push("bne_br", c);
    drain(32'hFE001CE3, 1'b1);

    push_fd("jal");
    c      = base(S_JAL);
    c.m2r  = M2R_PC;
    c.rw   = 1'b1;
    c.opc  = PC_ALUOUT;
    c.pc   = 1'b1;
    push("jal_j", c);
    drain(32'h010000EF, 1'b1);

    push_fd("jalr");
    c      = ex(S_JALR, A_REG, B_IMM, ALU_ADD);
    c.opc  = PC_JALR;
    c.pc   = 1'b1;
    c.m2r  = M2R_PC;
    c.rw   = 1'b1;
    push("jalr_j", c);
    drain(32'h00008067, 1'b1);

    push_fd("fence");
    drain(32'h0FF0000F, 1'b1);

    push_fd("csrrs0");
    push("csrrs0_exe", ex(S_CSR_EXE, A_REG, B_CSR, ALU_OR));
    push_csr_wb("csrrs0", 1'b0);
    drain(32'h000022F3, 1'b1);

    push_fd("csrrw");
    push("csrrw_exe", ex(S_CSR_EXE, A_REG, B_ZERO, ALU_ADD));
    push_csr_wb("csrrw", 1'b1);
    drain(32'h00009073, 1'b1);

    push_fd("csrrc");
    push("csrrc_exe", ex(S_CSR_EXE, A_NOT, B_CSR, ALU_AND));
    push_csr_wb("csrrc", 1'b1);
    drain(32'h00013073, 1'b1);

    push_fd("ecall");
    c       = base(S_ECALL);
    c.ecall = 1'b1;
    c.opc   = PC_UTVEC;
    c.pc    = 1'b1;
    push("ecall_x", c);
    drain(32'h00000073, 1'b1);

    push_fd("uret");
    c      = base(S_URET);
    c.opc  = PC_UEPC;
    c.pc   = 1'b1;
    push("uret_x", c);
    drain(32'h00200073, 1'b1);

    push_invalid("ebreak");
    drain(32'h00100073, 1'b1);
    push_invalid("op7f");
    drain(32'h0000007F, 1'b1);
    push_invalid("badf7");
    drain(32'h022081B3, 1'b1);
    push_invalid("ld");
    drain(32'h0080B203, 1'b1);
    push_invalid("f3_100");
    drain(32'h00014073, 1'b1);

    push_fd("lwrst");
    push("lwrst_addr", ex(S_ADDR, A_REG, B_IMM, ALU_ADD));
    drain(32'h0080A203, 1'b1);
    push("lwrst_inreset", '0);
    drain(32'h0080A203, 1'b0);

    push_fd("after_rst");
    push("after_rst_exe", ex(S_EXE_R, A_REG, B_REG, ALU_ADD));
    push_alu_wb("after_rst");
    drain(32'h002081B3, 1'b1);

    push_fd("tail");
    drain(32'h0FF0000F, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
